seq_detector_param: RTL and testbench

//   Parametrised serial sequence-detector FSM; successor to the fixed-pattern fsml detector.

---
 rtl/seq_detector_param.sv | 113 +++++++++++
 tb/tb_seq_detector_param.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Parametrised serial sequence detector with a run-time reloadable pattern, selectable overlap
// and a saturating match counter. The detector arms once a full pattern's worth of valid bits is held.
module seq_detector_param #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Din,
  input  logic             Din_valid,
  input  logic             Load,
  input  logic [PAT_W-1:0] Pattern_in,
  input  logic             Clear_count,
  output logic             Dout,
  output logic [CNT_W-1:0] Match_count
);

  localparam int                FILL_W    = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  // PH_FILL counts valid bits 0..PAT_W-1; PH_ARMED stands for fill == PAT_W.
  typedef enum logic {
    PH_FILL  = 1'b0,
    PH_ARMED = 1'b1
  } phase_t;

  phase_t             phase_r, phase_next_s;
  logic [FILL_W-1:0]  fill_r, fill_next_s;
  logic [PAT_W-1:0]   pat_r, pat_next_s;
  logic [PAT_W-1:0]   hist_r, hist_next_s;
  logic [PAT_W-1:0]   nh_s;
  logic               full_s;
  logic               match_s;
  logic               fire_s;
  logic               dout_next_s;
  logic [CNT_W-1:0]   count_next_s;

  // Next-state, match decode and counter update.
  always_comb begin
    nh_s         = {hist_r[PAT_W-2:0], Din};
    full_s       = (phase_r == PH_ARMED) || (fill_r == FILL_LAST);
    match_s      = full_s && (nh_s == pat_r);
    fire_s       = !Load && Din_valid && match_s;
    phase_next_s = phase_r;
    fill_next_s  = fill_r;
    pat_next_s   = pat_r;
    hist_next_s  = hist_r;
    dout_next_s  = 1'b0;
    count_next_s = Match_count;

    if (Load) begin
      pat_next_s   = Pattern_in;
      hist_next_s  = {PAT_W{1'b0}};
      fill_next_s  = {FILL_W{1'b0}};
      phase_next_s = PH_FILL;
    end else if (Din_valid) begin
      hist_next_s = nh_s;
      dout_next_s = match_s;
      if (match_s && !OVERLAP) begin
        fill_next_s  = {FILL_W{1'b0}};
        phase_next_s = PH_FILL;
      end else begin
        case (phase_r)
          PH_FILL: begin
            if (fill_r == FILL_LAST) begin
              phase_next_s = PH_ARMED;
            end else begin
              fill_next_s = fill_r + FILL_W'(1);
            end
          end
          PH_ARMED: phase_next_s = PH_ARMED;
          default: begin
            phase_next_s = PH_FILL;
            fill_next_s  = {FILL_W{1'b0}};
          end
        endcase
      end
    end else begin
      dout_next_s = 1'b0;
    end

    // A clear takes precedence over a match on the same edge.
    if (Clear_count) begin
      count_next_s = {CNT_W{1'b0}};
    end else if (fire_s && (Match_count != {CNT_W{1'b1}})) begin
      count_next_s = Match_count + CNT_W'(1);
    end else begin
      count_next_s = Match_count;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      phase_r     <= PH_FILL;
      fill_r      <= {FILL_W{1'b0}};
      pat_r       <= PATTERN;
      hist_r      <= {PAT_W{1'b0}};
      Dout        <= 1'b0;
      Match_count <= {CNT_W{1'b0}};
    end else begin
      phase_r     <= phase_next_s;
      fill_r      <= fill_next_s;
      pat_r       <= pat_next_s;
      hist_r      <= hist_next_s;
      Dout        <= dout_next_s;
      Match_count <= count_next_s;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: three instances (overlap, non-overlap, and a
// 2-bit-counter all-ones variant) share one stimulus stream.
module tb_seq_detector_param;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Din = 1'b0;
  logic       Din_valid = 1'b0;
  logic       Load = 1'b0;
  logic [3:0] Pattern_in = 4'b0000;
  logic       Clear_count = 1'b0;

  logic       dout_a, dout_b, dout_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  int errors = 0;
  int checks = 0;

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Din_valid(Din_valid), .Load(Load),
    .Pattern_in(Pattern_in), .Clear_count(Clear_count), .Dout(dout_a), .Match_count(cnt_a));

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Din_valid(Din_valid), .Load(Load),
    .Pattern_in(Pattern_in), .Clear_count(Clear_count), .Dout(dout_b), .Match_count(cnt_b));

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
    .Clock(Clock), .Reset(Reset), .Din(Din), .Din_valid(Din_valid), .Load(Load),
    .Pattern_in(Pattern_in), .Clear_count(Clear_count), .Dout(dout_c), .Match_count(cnt_c));

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; Din_valid = 1'b0; Load = 1'b0; Clear_count = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  task automatic send(input logic b, input logic clr);
    Din = b; Din_valid = 1'b1; Clear_count = clr;
    @(posedge Clock); #1;
    Din = 1'b0; Din_valid = 1'b0; Clear_count = 1'b0;
  endtask

  task automatic gap_a(input int n);
    for (int g = 0; g < n; g++) begin
      @(posedge Clock); #1;
      check_eq("gap_dout_a", 32'(dout_a), 32'd0);
    end
  endtask

  logic [6:0] t2_bits  = 7'b1011011;
  logic [6:0] t2_exp_a = 7'b0001001;
  logic [6:0] t2_exp_b = 7'b0001000;
  logic [7:0] t5_exp_d = 8'b00011111;
  logic [3:0] seq_a    = 4'b0110;
  logic [3:0] seq_b    = 4'b1011;

  initial begin
    // Reset state
    @(posedge Clock); #1;
    Reset = 1'b0;
    check_eq("rst_dout", 32'(dout_a), 32'd0);
    check_eq("rst_cnt",  32'(cnt_a),  32'd0);

    // 1: single match, one-cycle pulse
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    check_eq("t1_pre", 32'(dout_a), 32'd0);
    send(1'b1, 1'b0);
    check_eq("t1_pulse", 32'(dout_a), 32'd1);
    check_eq("t1_cnt", 32'(cnt_a), 32'd1);
    @(posedge Clock); #1;
    check_eq("t1_drop", 32'(dout_a), 32'd0);

    // 2: overlap vs non-overlap
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      send(t2_bits[i], 1'b0);
      check_eq("t2_dout_ov", 32'(dout_a), 32'(t2_exp_a[i]));
      check_eq("t2_dout_nov", 32'(dout_b), 32'(t2_exp_b[i]));
    end
    check_eq("t2_cnt_ov", 32'(cnt_a), 32'd2);
    check_eq("t2_cnt_nov", 32'(cnt_b), 32'd1);

    // 3: gaps between valid bits
    do_reset();
    send(1'b1, 1'b0); gap_a(1);
    send(1'b0, 1'b0); gap_a(2);
    send(1'b1, 1'b0); gap_a(3);
    send(1'b1, 1'b0);
    check_eq("t3_pulse", 32'(dout_a), 32'd1);
    gap_a(2);
    check_eq("t3_cnt", 32'(cnt_a), 32'd1);

    // 4: pattern reload discards history and the bit on the load edge
    do_reset();
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    Load = 1'b1; Pattern_in = 4'b0110; Din = 1'b1; Din_valid = 1'b1;
    @(posedge Clock); #1;
    Load = 1'b0; Din_valid = 1'b0;
    check_eq("t4_load_dout", 32'(dout_a), 32'd0);
    send(1'b1, 1'b0);
    check_eq("t4_after_load", 32'(dout_a), 32'd0);
    for (int i = 3; i >= 0; i--) begin
      send(seq_a[i], 1'b0);
      check_eq("t4_new_pat", 32'(dout_a), (i == 0) ? 32'd1 : 32'd0);
    end
    for (int i = 3; i >= 0; i--) begin
      send(seq_b[i], 1'b0);
      check_eq("t4_old_pat", 32'(dout_a), 32'd0);
    end
    check_eq("t4_cnt", 32'(cnt_a), 32'd1);

    // 5: all-ones pattern, 2-bit saturating counter, clear beats match
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      send(1'b1, 1'b0);
      check_eq("t5_dout", 32'(dout_c), 32'(t5_exp_d[i]));
    end
    check_eq("t5_sat", 32'(cnt_c), 32'd3);
    send(1'b1, 1'b1);
    check_eq("t5_clr_dout", 32'(dout_c), 32'd1);
    check_eq("t5_clr_cnt", 32'(cnt_c), 32'd0);
    send(1'b1, 1'b0);
    check_eq("t5_recount", 32'(cnt_c), 32'd1);

    // 6: reset mid-sequence forgets partial history
    do_reset();
    send(1'b1, 1'b0); send(1'b0, 1'b0); send(1'b1, 1'b0);
    do_reset();
    check_eq("t6_rst_cnt", 32'(cnt_a), 32'd0);
    send(1'b1, 1'b0);
    check_eq("t6_no_pulse", 32'(dout_a), 32'd0);
    for (int i = 3; i >= 0; i--) begin
      send(seq_b[i], 1'b0);
      check_eq("t6_seq", 32'(dout_a), (i == 0) ? 32'd1 : 32'd0);
    end
    check_eq("t6_cnt", 32'(cnt_a), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
